// File: rtl/ccff_loader.sv
// ccff_loader: configuration-chain loader. Accepts WORD_W-bit bitstream words over a
// valid/ready handshake and shifts them MSB first into the fabric chain head,
// issuing exactly BITSTREAM_SIZE shift enables per load.
// Optional chain self-test is compiled in with macro CCFF_CHAIN_CHECK_EN.
module ccff_loader #(
   parameter int unsigned BITSTREAM_SIZE = 29696,
   parameter int unsigned WORD_W         = 32,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              chk_start,
   input  logic [WORD_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic              busy,
   output logic              done,
   output logic              chk_err,
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam int unsigned WBW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [WBW-1:0]   WBIT_LAST = WBW'(WORD_W - 1);
   localparam logic [CNT_W-1:0] N_BITS    = CNT_W'(BITSTREAM_SIZE);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
`ifdef CCFF_CHAIN_CHECK_EN
   localparam logic [1:0] ST_CHECK = 2'd3;
   // Check runs cycles 0..N+1; the marker is expected at the tail in cycle N.
   localparam logic [CNT_W-1:0] N_CHK_LAST = CNT_W'(BITSTREAM_SIZE + 1);
`endif

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [WBW-1:0]    wbit_q, wbit_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              head_q, head_d;
   logic              shift_en_q, shift_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef CCFF_CHAIN_CHECK_EN
   logic              chk_err_q, chk_err_d;
`else
   logic              unused_chk;
   assign unused_chk = chk_start ^ ccff_tail;
`endif

   // Next-state logic; registered outputs are computed for the cycle being entered.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      wbit_d     = wbit_q;
      bit_cnt_d  = bit_cnt_q;
      head_d     = 1'b0;
      shift_en_d = 1'b0;
      done_d     = done_q;
`ifdef CCFF_CHAIN_CHECK_EN
      chk_err_d  = chk_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               done_d    = 1'b0;
               bit_cnt_d = '0;
`ifdef CCFF_CHAIN_CHECK_EN
               chk_err_d = 1'b0;
            end else if (chk_start) begin
               state_d    = ST_CHECK;
               done_d     = 1'b0;
               chk_err_d  = 1'b0;
               bit_cnt_d  = '0;
               shift_en_d = 1'b1;
               head_d     = 1'b1;
`endif
            end
         end
         ST_FETCH: begin
            if (wvalid) begin
               shreg_d    = wdata;
               wbit_d     = '0;
               state_d    = ST_SHIFT;
               shift_en_d = 1'b1;
               head_d     = wdata[WORD_W-1];
            end
         end
         ST_SHIFT: begin
            shreg_d   = shreg_q << 1;
            wbit_d    = wbit_q + 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_d == N_BITS) begin
               // Partial last word: its remaining low bits are dropped here.
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (wbit_q == WBIT_LAST) begin
               state_d = ST_FETCH;
            end else begin
               shift_en_d = 1'b1;
               head_d     = shreg_d[WORD_W-1];
            end
         end
`ifdef CCFF_CHAIN_CHECK_EN
         ST_CHECK: begin
            if (ccff_tail != (bit_cnt_q == N_BITS)) begin
               chk_err_d = 1'b1;
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == N_CHK_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               shift_en_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset returns everything to idle immediately.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         wbit_q     <= '0;
         bit_cnt_q  <= '0;
         head_q     <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         wbit_q     <= wbit_d;
         bit_cnt_q  <= bit_cnt_d;
         head_q     <= head_d;
         shift_en_q <= shift_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef CCFF_CHAIN_CHECK_EN
   // Sticky self-test error flag.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         chk_err_q <= 1'b0;
      end else begin
         chk_err_q <= chk_err_d;
      end
   end
   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

   assign wready    = (state_q == ST_FETCH);
   assign ccff_head = head_q;
   assign shift_en  = shift_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed self-checking bench for ccff_loader with a 70-flop chain and 32-bit words.
module tb_ccff_loader;

   localparam int N = 70;
   localparam int W = 32;

   logic          prog_clk = 1'b0;
   logic          pReset = 1'b0;
   logic          start = 1'b0;
   logic          chk_start = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          wvalid = 1'b0;
   logic          wready, ccff_head, ccff_tail, shift_en, busy, done, chk_err;
   logic [15:0]   bit_cnt;

   logic [N-1:0]  chain_q;
   int            chain_len = N;
   logic [W-1:0]  words [3];
   logic [N-1:0]  exp_chain;

   int n_tests = 0;
   int n_fail = 0;

   ccff_loader #(.BITSTREAM_SIZE(N), .WORD_W(W), .CNT_W(16)) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .start    (start),
      .chk_start(chk_start),
      .wdata    (wdata),
      .wvalid   (wvalid),
      .wready   (wready),
      .ccff_head(ccff_head),
      .ccff_tail(ccff_tail),
      .shift_en (shift_en),
      .busy     (busy),
      .done     (done),
      .chk_err  (chk_err),
      .bit_cnt  (bit_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: bit shifted first ends up at the MSB (tail end).
   always @(posedge prog_clk) begin
      if (shift_en) chain_q <= {chain_q[N-2:0], ccff_head};
   end
   assign ccff_tail = (chain_len == N) ? chain_q[N-1] : chain_q[N-2];

   task automatic step();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      words[0] = a;
      words[1] = b;
      words[2] = c;
      exp_chain = {a, b, c[31:26]};
   endtask

   // Pulses start then feeds words until done (bounded); gap = idle FETCH cycles per word.
   task automatic run_load(input int gap, input int restart_at, output int cycles,
                           output int shifts, output int accepted, output int head_gap);
      int  wait_cnt;
      bit  xfer;
      cycles = 0; shifts = 0; accepted = 0; head_gap = 0; wait_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (!done && cycles < 500) begin
         if (shift_en) shifts++;
         else if (ccff_head) head_gap++;
         start = (cycles == restart_at);
         if (wready && wait_cnt >= gap) begin
            wvalid = 1'b1;
            wdata  = (accepted < 3) ? words[accepted] : '0;
         end else if (wready) begin
            wvalid = 1'b0;
            wdata  = 32'hFFFF_FFFF;
            wait_cnt++;
         end else begin
            wvalid = (gap == 0);
            wdata  = 32'hA5A5_A5A5;
         end
         xfer = wready && wvalid;
         step();
         cycles++;
         if (xfer) begin
            accepted++;
            wait_cnt = 0;
         end
      end
      start  = 1'b0;
      wvalid = 1'b0;
   endtask

   task automatic test_reset();
      pReset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start     = 1'($urandom_range(0, 1));
         chk_start = 1'($urandom_range(0, 1));
         wvalid    = 1'($urandom_range(0, 1));
         wdata     = $urandom;
         step();
         n_tests++;
         if ({wready, ccff_head, shift_en, busy, done, chk_err, bit_cnt} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {wready, ccff_head, shift_en, busy, done, chk_err, bit_cnt});
         end
      end
      start = 1'b0; chk_start = 1'b0; wvalid = 1'b0;
      #2 pReset = 1'b1;
      repeat (3) step();
      n_tests++;
      if ({wready, busy, shift_en} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got wready/busy/shift_en=%b expected 000",
                  {wready, busy, shift_en});
      end
   endtask

   task automatic test_full_load();
      int cyc, sh, acc, hg;
      set_words(32'hDEAD_BEEF, 32'h1234_5678, 32'hC3FF_0001);
      run_load(0, -1, cyc, sh, acc, hg);
      n_tests++;
      if (cyc != 73) begin n_fail++; $display("FAIL full_cycles: got %0d expected 73", cyc); end
      n_tests++;
      if (sh != 70) begin n_fail++; $display("FAIL full_shifts: got %0d expected 70", sh); end
      n_tests++;
      if (acc != 3) begin n_fail++; $display("FAIL full_words: got %0d expected 3", acc); end
      n_tests++;
      if ({done, busy, shift_en, chk_err} !== 4'b1000) begin
         n_fail++;
         $display("FAIL full_flags: got done/busy/shift_en/chk_err=%b expected 1000",
                  {done, busy, shift_en, chk_err});
      end
      n_tests++;
      if (bit_cnt !== 16'd70) begin
         n_fail++; $display("FAIL full_bit_cnt: got %0d expected 70", bit_cnt);
      end
      n_tests++;
      if (chain_q !== exp_chain) begin
         n_fail++; $display("FAIL full_chain: got %h expected %h", chain_q, exp_chain);
      end
      repeat (3) step();
      n_tests++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b expected 1", done); end
   endtask

   task automatic test_backpressure();
      int cyc, sh, acc, hg;
      set_words(32'h5555_AAAA, 32'h0000_FFFF, 32'h9BFF_FFFF);
      run_load(5, -1, cyc, sh, acc, hg);
      n_tests++;
      if (cyc != 88) begin n_fail++; $display("FAIL bp_cycles: got %0d expected 88", cyc); end
      n_tests++;
      if (sh != 70) begin n_fail++; $display("FAIL bp_shifts: got %0d expected 70", sh); end
      n_tests++;
      if (hg != 0) begin n_fail++; $display("FAIL bp_head_gap: got %0d expected 0", hg); end
      n_tests++;
      if (chain_q !== exp_chain) begin
         n_fail++; $display("FAIL bp_chain: got %h expected %h", chain_q, exp_chain);
      end
   endtask

   task automatic test_restart_ignored();
      int cyc, sh, acc, hg;
      set_words(32'h0F0F_3C3C, 32'hF00D_CAFE, 32'h6BAD_F00D);
      run_load(0, 30, cyc, sh, acc, hg);
      n_tests++;
      if (cyc != 73 || sh != 70) begin
         n_fail++; $display("FAIL restart_timing: got cycles=%0d shifts=%0d expected 73/70", cyc, sh);
      end
      n_tests++;
      if (chain_q !== exp_chain || bit_cnt !== 16'd70) begin
         n_fail++;
         $display("FAIL restart_chain: got %h cnt=%0d expected %h cnt=70", chain_q, bit_cnt, exp_chain);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, sh, acc, hg;
      set_words(32'h8000_0001, 32'h7FFF_FFFE, 32'h5400_0000);
      start = 1'b1;
      step();
      start = 1'b0;
      n_tests++;
      if ({done, busy, wready} !== 3'b011 || bit_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL b2b_start: got done/busy/wready=%b cnt=%0d expected 011 cnt=0",
                  {done, busy, wready}, bit_cnt);
      end
      run_load(0, -1, cyc, sh, acc, hg);
      n_tests++;
      if (sh != 70 || chain_q !== exp_chain || done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_load: got shifts=%0d chain=%h done=%b expected 70 %h 1",
                  sh, chain_q, done, exp_chain);
      end
   endtask

   task automatic test_reset_mid();
      int  cyc, sh, acc, hg;
      bit  xfer;
      set_words(32'h0123_4567, 32'h89AB_CDEF, 32'hA7FF_FFFF);
      sh = 0; acc = 0; cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 200) begin
         if (shift_en) sh++;
         if (sh == 40) break;
         wvalid = wready;
         wdata  = words[(acc < 3) ? acc : 0];
         xfer   = wready;
         step();
         if (xfer) acc++;
         cyc++;
      end
      wvalid = 1'b0;
      n_tests++;
      if (sh != 40 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_reach: got shifts=%0d busy=%b expected 40 1", sh, busy);
      end
      pReset = 1'b0;
      #1;
      n_tests++;
      if ({wready, ccff_head, shift_en, busy, done, chk_err, bit_cnt} !== 22'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %b expected all zero",
                  {wready, ccff_head, shift_en, busy, done, chk_err, bit_cnt});
      end
      step();
      pReset = 1'b1;
      step();
      run_load(0, -1, cyc, sh, acc, hg);
      n_tests++;
      if (sh != 70 || cyc != 73 || chain_q !== exp_chain || done !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reload: got shifts=%0d cycles=%0d chain=%h done=%b expected 70 73 %h 1",
                  sh, cyc, chain_q, done, exp_chain);
      end
   endtask

`ifdef CCFF_CHAIN_CHECK_EN
   // Clears the chain with a zero load, then runs the self-test against a len-flop model.
   task automatic run_check(input int len, output int shifts);
      int cyc, acc, hg, sh0;
      chain_len = N;
      set_words('0, '0, '0);
      run_load(0, -1, cyc, sh0, acc, hg);
      chain_len = len;
      shifts = 0; cyc = 0;
      chk_start = 1'b1;
      step();
      chk_start = 1'b0;
      while (!done && cyc < 200) begin
         if (shift_en) shifts++;
         step();
         cyc++;
      end
   endtask

   task automatic test_chain_check();
      int sh;
      run_check(70, sh);
      n_tests++;
      if (sh != 72 || bit_cnt !== 16'd72 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL chk70_run: got shifts=%0d cnt=%0d done=%b expected 72 72 1", sh, bit_cnt, done);
      end
      n_tests++;
      if (chk_err !== 1'b0) begin n_fail++; $display("FAIL chk70_err: got %b expected 0", chk_err); end
      run_check(69, sh);
      n_tests++;
      if (chk_err !== 1'b1 || sh != 72) begin
         n_fail++; $display("FAIL chk69_err: got err=%b shifts=%0d expected 1 72", chk_err, sh);
      end
      chain_len = N;
   endtask
`else
   task automatic test_no_check();
      int act;
      act = 0;
      chk_start = 1'b1;
      step();
      chk_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (shift_en || busy || wready) act++;
         step();
      end
      n_tests++;
      if (act != 0 || chk_err !== 1'b0) begin
         n_fail++; $display("FAIL nochk_idle: got activity=%0d chk_err=%b expected 0 0", act, chk_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_load();
      test_backpressure();
      test_restart_ignored();
      test_back_to_back();
      test_reset_mid();
`ifdef CCFF_CHAIN_CHECK_EN
      test_chain_check();
`else
      test_no_check();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
